// File: rtl/pll_reconfig_pkg.sv
// Shared types for the PLL reconfiguration sequencer: FSM states, counter/param codes, write command.
// Pure declarations, no logic or timing of its own.
package pll_reconfig_pkg;

  typedef enum logic [3:0] {
    RST_PLL,
    RST_RC,
    IDLE,
    SET,
    WRITE,
    WAIT,
    RECONFIG,
    WAIT_BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CT_N  = 4'b0000;
  localparam logic [3:0] CT_M  = 4'b0001;
  localparam logic [3:0] CT_C0 = 4'b0100;

  localparam logic [2:0] CP_HIGH   = 3'b000;
  localparam logic [2:0] CP_LOW    = 3'b001;
  localparam logic [2:0] CP_BYPASS = 3'b100;
  localparam logic [2:0] CP_ODD    = 3'b101;

  typedef struct packed {
    logic [3:0] counter_type;
    logic [2:0] counter_param;
    logic [8:0] config_data;
  } wr_cmd_t;

  // Counter index 0 is N, 1 is M, 2.. are the post-scale C counters.
  function automatic logic [3:0] type_code(input logic [3:0] idx);
    if (idx == 4'd0)      return CT_N;
    else if (idx == 4'd1) return CT_M;
    else                  return CT_C0 + (idx - 4'd2);
  endfunction

  function automatic logic [2:0] param_code(input logic [1:0] idx);
    case (idx)
      2'd0:    return CP_HIGH;
      2'd1:    return CP_LOW;
      2'd2:    return CP_BYPASS;
      default: return CP_ODD;
    endcase
  endfunction

endpackage

// File: rtl/pll_param_calc.sv
// Splits one divide factor into high/low phase counts plus bypass and odd flags.
// Purely combinational, zero latency, no flow control.
module pll_param_calc (
  input  logic [7:0] factor,
  output logic [7:0] high,
  output logic [7:0] low,
  output logic       bypass,
  output logic       odd
);

  logic [8:0] sum;

  // Nine bits so a factor of 255 rounds up to 128 without overflow.
  assign sum    = {1'b0, factor} + 9'd1;
  assign high   = sum[8:1];
  assign low    = factor - high;
  assign bypass = (factor <= 8'd1);
  assign odd    = factor[0];

endmodule

// File: rtl/pll_reconfig_seq.sv
// Writes N, M and C counter params into the PLL reconfig core, triggers reconfig, waits on busy_in.
// All outputs registered from next state; busy_in stalls writes. Macro PLL_RECONFIG_TIMEOUT_EN adds busy timeout.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_C      = 2,
  parameter int PARAM_CYC  = 5,
  parameter int SETTLE_CYC = 10,
  parameter int BUSY_TMO   = 1023
) (
  input  logic               clock_ctr,
  input  logic               sys_reset,
  input  logic               start,
  input  logic               busy_in,
  input  logic [7:0]         n_factor,
  input  logic [7:0]         m_factor,
  input  logic [NUM_C*8-1:0] c_factor,
  output logic [3:0]         counter_type,
  output logic [2:0]         counter_param,
  output logic [8:0]         config_data,
  output logic               write_param,
  output logic               reconfig,
  output logic               reset_rc,
  output logic               pll_areset,
  output logic               ready,
  output logic               done,
  output logic               error
);

  localparam int DLY_MAX = (PARAM_CYC > SETTLE_CYC) ? PARAM_CYC : SETTLE_CYC;
  localparam int CW      = $clog2(DLY_MAX + 1);
  localparam logic [CW-1:0] PARAM_LD  = CW'(PARAM_CYC - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
  localparam logic [3:0]    LAST_CTR  = 4'(NUM_C + 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      dly, dly_nxt;
  logic [3:0]         ctr_idx, ctr_idx_nxt;
  logic [1:0]         par_idx, par_idx_nxt;
  logic               busy_seen, busy_seen_nxt;
  logic [7:0]         n_q, m_q, n_cur, m_cur, sel_f;
  logic [NUM_C*8-1:0] c_q, c_cur;
  logic               accept, tmo;
  logic [7:0]         f_high, f_low, pval;
  logic               f_bypass, f_odd;
  wr_cmd_t            cmd_q, cmd_nxt;
  logic               cmd_load;
  logic               pll_areset_nxt, reset_rc_nxt, ready_nxt, write_param_nxt;
  logic               reconfig_nxt, done_nxt, error_nxt;

  assign accept = (state == IDLE) && start;

`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam int TW = $clog2(BUSY_TMO + 1);
  logic [TW-1:0] busy_cnt;
  logic          busy_watch;

  assign busy_watch = busy_in && ((state == WAIT) || (state == WAIT_BUSY));
  assign tmo        = busy_watch && (busy_cnt == TW'(BUSY_TMO - 1));

  always_ff @(posedge clock_ctr or negedge sys_reset) begin
    if (!sys_reset)               busy_cnt <= '0;
    else if (busy_watch && !tmo)  busy_cnt <= busy_cnt + TW'(1);
    else                          busy_cnt <= '0;
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clock_ctr or negedge sys_reset) begin
    if (!sys_reset) state <= RST_PLL;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RST_PLL:   if (dly == '0) state_nxt = RST_RC;
      RST_RC:    if (dly == '0) state_nxt = IDLE;
      IDLE:      if (start) state_nxt = SET;
      SET:       if (dly == '0) state_nxt = WRITE;
      WRITE:     state_nxt = WAIT;
      WAIT: begin
        if (tmo)
          state_nxt = RST_PLL;
        else if (!busy_in && (dly == '0))
          state_nxt = ((ctr_idx == LAST_CTR) && (par_idx == 2'd3)) ? RECONFIG : SET;
      end
      RECONFIG:  state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tmo)                       state_nxt = RST_PLL;
        else if (busy_seen && !busy_in) state_nxt = DONE;
      end
      DONE:      state_nxt = IDLE;
      default:   state_nxt = RST_PLL;
    endcase
  end

  // Shared delay counter: reloaded on every state entry; busy in WAIT restarts the settle window.
  always_comb begin
    dly_nxt = (dly != '0) ? dly - CW'(1) : dly;
    if (state_nxt != state) begin
      case (state_nxt)
        RST_RC:  dly_nxt = SETTLE_LD;
        SET:     dly_nxt = PARAM_LD;
        WAIT:    dly_nxt = SETTLE_LD;
        default: dly_nxt = '0;
      endcase
    end else if ((state == WAIT) && busy_in) begin
      dly_nxt = SETTLE_LD;
    end

    ctr_idx_nxt = ctr_idx;
    par_idx_nxt = par_idx;
    if (accept) begin
      ctr_idx_nxt = '0;
      par_idx_nxt = '0;
    end else if ((state == WAIT) && (state_nxt == SET)) begin
      par_idx_nxt = par_idx + 2'd1;
      if (par_idx == 2'd3) ctr_idx_nxt = ctr_idx + 4'd1;
    end

    busy_seen_nxt = (state == WAIT_BUSY) ? (busy_seen | busy_in) : 1'b0;

    n_cur = accept ? n_factor : n_q;
    m_cur = accept ? m_factor : m_q;
    c_cur = accept ? c_factor : c_q;
  end

  always_comb begin
    sel_f = n_cur;
    if (ctr_idx_nxt == 4'd1) sel_f = m_cur;
    for (int i = 0; i < NUM_C; i++) begin
      if (ctr_idx_nxt == 4'(i + 2)) sel_f = c_cur[i*8 +: 8];
    end
  end

  pll_param_calc u_calc (
    .factor (sel_f),
    .high   (f_high),
    .low    (f_low),
    .bypass (f_bypass),
    .odd    (f_odd)
  );

  always_comb begin
    case (par_idx_nxt)
      2'd0:    pval = f_high;
      2'd1:    pval = f_low;
      2'd2:    pval = {7'd0, f_bypass};
      default: pval = {7'd0, f_odd};
    endcase
    cmd_nxt.counter_type  = type_code(ctr_idx_nxt);
    cmd_nxt.counter_param = param_code(par_idx_nxt);
    cmd_nxt.config_data   = {1'b0, pval};
  end

  always_comb begin
    pll_areset_nxt  = (state_nxt == RST_PLL);
    reset_rc_nxt    = (state_nxt == RST_RC);
    ready_nxt       = (state_nxt == IDLE);
    write_param_nxt = (state_nxt == WRITE);
    reconfig_nxt    = (state_nxt == RECONFIG);
    done_nxt        = (state_nxt == DONE);
    cmd_load        = (state_nxt == SET) && (state != SET);
    error_nxt       = error;
    if (accept) error_nxt = 1'b0;
    if (tmo)    error_nxt = 1'b1;
  end

  // Counter resets to 1 so RST_PLL lasts one visible cycle after release.
  always_ff @(posedge clock_ctr or negedge sys_reset) begin
    if (!sys_reset) begin
      dly         <= CW'(1);
      ctr_idx     <= '0;
      par_idx     <= '0;
      busy_seen   <= 1'b0;
      n_q         <= '0;
      m_q         <= '0;
      c_q         <= '0;
      cmd_q       <= '0;
      pll_areset  <= 1'b0;
      reset_rc    <= 1'b0;
      ready       <= 1'b0;
      write_param <= 1'b0;
      reconfig    <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      dly         <= dly_nxt;
      ctr_idx     <= ctr_idx_nxt;
      par_idx     <= par_idx_nxt;
      busy_seen   <= busy_seen_nxt;
      n_q         <= n_cur;
      m_q         <= m_cur;
      c_q         <= c_cur;
      if (cmd_load) cmd_q <= cmd_nxt;
      pll_areset  <= pll_areset_nxt;
      reset_rc    <= reset_rc_nxt;
      ready       <= ready_nxt;
      write_param <= write_param_nxt;
      reconfig    <= reconfig_nxt;
      done        <= done_nxt;
      error       <= error_nxt;
    end
  end

  assign counter_type  = cmd_q.counter_type;
  assign counter_param = cmd_q.counter_param;
  assign config_data   = cmd_q.config_data;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: directed sequences, busy stalls, abort and timeout.
`timescale 1ns/1ps
module tb_pll_reconfig_seq;

  localparam int NUM_C = 2;
`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam int BUSY_TMO = 15;
`else
  localparam int BUSY_TMO = 1023;
`endif
  localparam logic [1:0] KIND_WR = 2'd0;
  localparam logic [1:0] KIND_RC = 2'd1;
  localparam logic [1:0] KIND_DN = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] ctype;
    logic [2:0] cparam;
    logic [8:0] data;
  } ev_t;

  logic        clock_ctr = 1'b0;
  logic        sys_reset = 1'b0;
  logic        start = 1'b0;
  logic        core_busy = 1'b0;
  logic        force_busy = 1'b0;
  logic        busy_in;
  logic [7:0]  n_factor = '0;
  logic [7:0]  m_factor = '0;
  logic [15:0] c_factor = '0;
  logic [3:0]  counter_type;
  logic [2:0]  counter_param;
  logic [8:0]  config_data;
  logic        write_param, reconfig, reset_rc, pll_areset, ready, done, error;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  assign busy_in = core_busy | force_busy;

  always #5 clock_ctr = ~clock_ctr;

  pll_reconfig_seq #(
    .NUM_C(NUM_C), .PARAM_CYC(5), .SETTLE_CYC(10), .BUSY_TMO(BUSY_TMO)
  ) dut (
    .clock_ctr(clock_ctr), .sys_reset(sys_reset), .start(start), .busy_in(busy_in),
    .n_factor(n_factor), .m_factor(m_factor), .c_factor(c_factor),
    .counter_type(counter_type), .counter_param(counter_param), .config_data(config_data),
    .write_param(write_param), .reconfig(reconfig), .reset_rc(reset_rc),
    .pll_areset(pll_areset), .ready(ready), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon_event(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual=%0h required=none", got);
    end else begin
      e = exp_q.pop_front();
      check("event", 32'(got), 32'(e));
    end
  endtask

  // Monitor: every write/reconfig/done pulse must match the head of the expected queue.
  always @(negedge clock_ctr) begin
    if (sys_reset) begin
      if (write_param) mon_event('{KIND_WR, counter_type, counter_param, config_data});
      if (reconfig)    mon_event('{KIND_RC, 4'd0, 3'd0, 9'd0});
      if (done)        mon_event('{KIND_DN, 4'd0, 3'd0, 9'd0});
    end
  end

  // Reconfig core model: busy rises two cycles after reconfig and holds for four.
  initial begin
    forever begin
      @(posedge clock_ctr); #1;
      if (reconfig) begin
        repeat (2) @(posedge clock_ctr);
        #1 core_busy = 1'b1;
        repeat (4) @(posedge clock_ctr);
        #1 core_busy = 1'b0;
      end
    end
  end

  task automatic push_wr(input logic [3:0] t, input logic [2:0] p, input logic [8:0] d);
    exp_q.push_back('{KIND_WR, t, p, d});
  endtask

  task automatic push_ctr(input logic [3:0] t, input logic [7:0] h, input logic [7:0] l,
                          input logic b, input logic o);
    push_wr(t, 3'b000, {1'b0, h});
    push_wr(t, 3'b001, {1'b0, l});
    push_wr(t, 3'b100, {8'd0, b});
    push_wr(t, 3'b101, {8'd0, o});
  endtask

  task automatic push_end();
    exp_q.push_back('{KIND_RC, 4'd0, 3'd0, 9'd0});
    exp_q.push_back('{KIND_DN, 4'd0, 3'd0, 9'd0});
  endtask

  task automatic tick();
    @(posedge clock_ctr); #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {counter_type, counter_param, config_data, write_param, reconfig,
                 reset_rc, pll_areset, ready, done, error}, 0);
  endtask

  // Caller sits 1ns after a posedge with sys_reset low.
  task automatic release_and_check();
    sys_reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("rst_seq_c%0d", k), {pll_areset, reset_rc, ready},
            {(k == 1), (k >= 2 && k <= 11), (k == 12)});
    end
  endtask

  task automatic do_start(input logic [7:0] n, input logic [7:0] m, input logic [7:0] c0,
                          input logic [7:0] c1);
    n_factor = n;
    m_factor = m;
    c_factor = {c1, c0};
    start    = 1'b1;
    tick();
    start    = 1'b0;
    check("ready_drop", ready, 0);
  endtask

  task automatic wait_ready(input int limit, input string name);
    int n = 0;
    while (ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check(name, ready, 1);
  endtask

  task automatic wait_write(input int limit, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (write_param !== 1'b1 && n < limit);
    check(name, write_param, 1);
  endtask

  initial begin
    int gap, wc, cyc;

    // Reset state and release sequence
    repeat (3) tick();
    check_all_zero("reset_outputs");
    release_and_check();

    // Sequence 1: n=1 m=12 c0=5 c1=4, first write stalled by busy for 20 cycles
    push_ctr(4'b0000, 8'd1, 8'd0, 1'b1, 1'b1);
    push_ctr(4'b0001, 8'd6, 8'd6, 1'b0, 1'b0);
    push_ctr(4'b0100, 8'd3, 8'd2, 1'b0, 1'b1);
    push_ctr(4'b0101, 8'd2, 8'd2, 1'b0, 1'b0);
    push_end();
    do_start(8'd1, 8'd12, 8'd5, 8'd4);
    wait_write(50, "seq1_first_write");
    force_busy = 1'b1;
    repeat (20) tick();
    check("hold_during_busy", {counter_type, counter_param, config_data},
          {4'b0000, 3'b000, 9'd1});
    tick();
    force_busy = 1'b0;
    gap = 21;
    while (write_param !== 1'b1 && gap < 100) begin
      tick();
      gap++;
    end
    check("busy_gap", gap, 36);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (write_param !== 1'b1 && gap < 100);
    check("normal_gap", gap, 16);
    wait_ready(600, "seq1_complete");
    check("seq1_queue_empty", exp_q.size(), 0);

    // Abort with sys_reset during the C0 high write
    push_ctr(4'b0000, 8'd4, 8'd3, 1'b0, 1'b1);
    push_ctr(4'b0001, 8'd1, 8'd1, 1'b0, 1'b0);
    do_start(8'd7, 8'd2, 8'd6, 8'd6);
    wc = (write_param === 1'b1) ? 1 : 0;
    cyc = 0;
    while (wc < 9 && cyc < 400) begin
      tick();
      cyc++;
      if (write_param === 1'b1) wc++;
    end
    check("c0_write_reached", wc, 9);
    check("c0_write_type", counter_type, 4'b0100);
    sys_reset = 1'b0;
    #1;
    check_all_zero("abort_outputs");
    check("abort_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) tick();
    check_all_zero("abort_held");
    release_and_check();

    // Sequence 2: n=0 m=3 c0=2 c1=255, start retriggered mid-sequence with new factors
    push_ctr(4'b0000, 8'd0, 8'd0, 1'b1, 1'b0);
    push_ctr(4'b0001, 8'd2, 8'd1, 1'b0, 1'b1);
    push_ctr(4'b0100, 8'd1, 8'd1, 1'b0, 1'b0);
    push_ctr(4'b0101, 8'd128, 8'd127, 1'b0, 1'b1);
    push_end();
    do_start(8'd0, 8'd3, 8'd2, 8'd255);
    repeat (100) tick();
    check("ready_mid_seq", ready, 0);
    n_factor = 8'd9;
    m_factor = 8'd9;
    c_factor = {8'd9, 8'd9};
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_ready(600, "seq2_complete");
    check("seq2_queue_empty", exp_q.size(), 0);
    check("seq2_error", error, 0);

    // busy_in stuck high after the first write
    push_wr(4'b0000, 3'b000, 9'd3);
    do_start(8'd5, 8'd5, 8'd5, 8'd5);
    wait_write(50, "stuck_first_write");
    force_busy = 1'b1;
`ifdef PLL_RECONFIG_TIMEOUT_EN
    gap = 0;
    while (error !== 1'b1 && gap < 100) begin
      tick();
      gap++;
    end
    check("tmo_cycles", gap, 16);
    check("tmo_pll_areset", pll_areset, 1);
    force_busy = 1'b0;
    wait_ready(40, "tmo_replay_ready");
    check("tmo_error_sticky", error, 1);
    check("tmo_queue_empty", exp_q.size(), 0);
    push_ctr(4'b0000, 8'd1, 8'd0, 1'b1, 1'b1);
    push_ctr(4'b0001, 8'd6, 8'd6, 1'b0, 1'b0);
    push_ctr(4'b0100, 8'd3, 8'd2, 1'b0, 1'b1);
    push_ctr(4'b0101, 8'd2, 8'd2, 1'b0, 1'b0);
    push_end();
    do_start(8'd1, 8'd12, 8'd5, 8'd4);
    check("tmo_error_cleared", error, 0);
    wait_ready(600, "seq3_complete");
    check("seq3_queue_empty", exp_q.size(), 0);
`else
    repeat (60) tick();
    check("stuck_error_low", error, 0);
    check("stuck_ready_low", ready, 0);
    check("stuck_queue_empty", exp_q.size(), 0);
    force_busy = 1'b0;
    sys_reset = 1'b0;
    #1;
    check_all_zero("stuck_abort_outputs");
    repeat (2) tick();
    release_and_check();
`endif

    repeat (5) tick();
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
